// File: rtl/bv4_mul_sched_pkg.sv
// Shared types for the sequential GF(2^4) tower-field multiplier (normal basis over GF(2^2)).
package bv4_mul_sched_pkg;

    typedef logic [1:0] bv2_t;
    typedef bv2_t [1:0] bv4_t;   // [1] = high half, [0] = low half

    typedef enum logic [1:0] {
        IDLE,
        MUL_H,
        MUL_L,
        MUL_S
    } mul_sched_state_t;

    // Scale by N in the GF(2^2) normal basis: {bit1, bit0} = {x0^x1, x1}.
    function automatic bv2_t bv2_scl_n(input bv2_t x);
        return {x[0] ^ x[1], x[1]};
    endfunction

endpackage

// File: rtl/bv4_mul_sched_mul2.sv
// GF(2^2) multiplier in normal basis; purely combinational, shared by the scheduler.
module bv4_mul_sched_mul2
    import bv4_mul_sched_pkg::*;
(
    input  bv2_t x,
    input  bv2_t y,
    output bv2_t z
);

    logic t;

    assign t = (x[1] ^ x[0]) & (y[1] ^ y[0]);
    assign z = {(x[1] & y[1]) ^ t, (x[0] & y[0]) ^ t};

endmodule

// File: rtl/bv4_mul_sched.sv
// Round-robin scheduled GF(2^4) multiplier: one GF(2^2) multiplier reused over three cycles.
// Optional BV4_MUL_SCHED_CLEAR_EN zeroes operand/partial registers when idle to stop toggling.
module bv4_mul_sched
    import bv4_mul_sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                in_clock,
    input  logic                in_reset,
    input  logic [NUM_REQ-1:0]  in_valid,
    output logic [NUM_REQ-1:0]  out_ready_req,
    input  bv4_t [NUM_REQ-1:0]  in_a,
    input  bv4_t [NUM_REQ-1:0]  in_b,
    output logic                out_valid,
    input  logic                in_ready,
    output bv4_t                out_c,
    output logic [ID_W-1:0]     out_id
);

    mul_sched_state_t   state_q;
    bv4_t               a_q;
    bv4_t               b_q;
    bv2_t               p_h_q;
    bv2_t               p_l_q;
    logic [ID_W-1:0]    id_q;
    logic [ID_W-1:0]    last_q;

    logic               arb_en;
    logic               found;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;

    bv2_t               mul_x;
    bv2_t               mul_y;
    bv2_t               mul_z;
    bv2_t               e;

    // A stalled result blocks new work unless it is being consumed this very cycle.
    assign arb_en = (state_q == IDLE) && (!out_valid || in_ready);

    // NOTE: every variable written in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        found    = 1'b0;
        grant    = '0;
        grant_id = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!found && in_valid[(int'(last_q) + i) % NUM_REQ]) begin
                found = 1'b1;
                grant[(int'(last_q) + i) % NUM_REQ] = 1'b1;
                grant_id = ID_W'((int'(last_q) + i) % NUM_REQ);
            end
        end
    end

    assign out_ready_req = arb_en ? grant : '0;

    always_comb begin
        mul_x = a_q[1];
        mul_y = b_q[1];
        case (state_q)
            MUL_H: begin
                mul_x = a_q[1];
                mul_y = b_q[1];
            end
            MUL_L: begin
                mul_x = a_q[0];
                mul_y = b_q[0];
            end
            MUL_S: begin
                mul_x = a_q[1] ^ a_q[0];
                mul_y = b_q[1] ^ b_q[0];
            end
            default: begin
`ifdef BV4_MUL_SCHED_CLEAR_EN
                mul_x = '0;
                mul_y = '0;
`else
                mul_x = a_q[1];
                mul_y = b_q[1];
`endif
            end
        endcase
    end

    bv4_mul_sched_mul2 u_mul2 (
        .x (mul_x),
        .y (mul_y),
        .z (mul_z)
    );

    assign e = bv2_scl_n(mul_z);

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            // NOTE: the operand/partial registers are reset too, so an aborted operation leaves nothing behind.
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            p_h_q     <= '0;
            p_l_q     <= '0;
            id_q      <= '0;
            last_q    <= ID_W'(NUM_REQ - 1);
            out_valid <= 1'b0;
            out_c     <= '0;
            out_id    <= '0;
        end else begin
            if (out_valid && in_ready) begin
                out_valid <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (|out_ready_req) begin
                        a_q     <= in_a[grant_id];
                        b_q     <= in_b[grant_id];
                        id_q    <= grant_id;
                        state_q <= MUL_H;
                    end
`ifdef BV4_MUL_SCHED_CLEAR_EN
                    else if (out_valid && in_ready) begin
                        a_q   <= '0;
                        b_q   <= '0;
                        p_h_q <= '0;
                        p_l_q <= '0;
                    end
`endif
                end
                MUL_H: begin
                    p_h_q   <= mul_z;
                    state_q <= MUL_L;
                end
                MUL_L: begin
                    p_l_q   <= mul_z;
                    state_q <= MUL_S;
                end
                MUL_S: begin
                    out_c     <= {p_h_q ^ e, p_l_q ^ e};
                    out_id    <= id_q;
                    out_valid <= 1'b1;
                    last_q    <= id_q;
                    state_q   <= IDLE;
`ifdef BV4_MUL_SCHED_CLEAR_EN
                    a_q       <= '0;
                    b_q       <= '0;
                    p_h_q     <= '0;
                    p_l_q     <= '0;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bv4_mul_sched.sv
// Bench for bv4_mul_sched: table-based GF(2^4) model, arbitration model and result scoreboard.
module tb_bv4_mul_sched;
    import bv4_mul_sched_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;

    logic                in_clock = 1'b0;
    logic                in_reset;
    logic [NUM_REQ-1:0]  in_valid;
    logic [NUM_REQ-1:0]  out_ready_req;
    bv4_t [NUM_REQ-1:0]  in_a;
    bv4_t [NUM_REQ-1:0]  in_b;
    logic                out_valid;
    logic                in_ready;
    bv4_t                out_c;
    logic [ID_W-1:0]     out_id;

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    bv4_mul_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .in_clock      (in_clock),
        .in_reset      (in_reset),
        .in_valid      (in_valid),
        .out_ready_req (out_ready_req),
        .in_a          (in_a),
        .in_b          (in_b),
        .out_valid     (out_valid),
        .in_ready      (in_ready),
        .out_c         (out_c),
        .out_id        (out_id)
    );

    always #5 in_clock = ~in_clock;
    always @(posedge in_clock) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // GF(2^2) normal basis {W^2, W}: 1=W (01), 2=W^2 (10), 3=one (11).
    function automatic logic [1:0] gf2(input logic [1:0] x, input logic [1:0] y);
        logic [1:0] tab [16];
        tab = '{2'd0, 2'd0, 2'd0, 2'd0,
                2'd0, 2'd2, 2'd3, 2'd1,
                2'd0, 2'd3, 2'd1, 2'd2,
                2'd0, 2'd1, 2'd2, 2'd3};
        return tab[{x, y}];
    endfunction

    function automatic logic [3:0] model_mul(input logic [3:0] a, input logic [3:0] b);
        logic [1:0] s;
        logic [1:0] e;
        s = gf2(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]);
        e = {s[0] ^ s[1], s[1]};
        return {gf2(a[3:2], b[3:2]) ^ e, gf2(a[1:0], b[1:0]) ^ e};
    endfunction

    function automatic int model_pick(input logic [NUM_REQ-1:0] v, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    typedef struct {
        logic [3:0] c;
        int         id;
        int         due;
    } exp_t;

    exp_t q[$];
    int   m_last = NUM_REQ - 1;
    int   m_free = 0;
    int   m_pick;
    logic m_valid;
    logic [NUM_REQ-1:0] m_grant;

    // Compare process: outputs are sampled on the falling edge, inputs are stable until the next rise.
    always @(negedge in_clock) begin
        if (in_reset) begin
            q.delete();
            m_last = NUM_REQ - 1;
            m_free = 0;
        end else begin
            m_valid = (q.size() > 0) && (cycle >= q[0].due);
            check("sb_valid", out_valid, m_valid);
            if (m_valid) begin
                check("sb_c", out_c, q[0].c);
                check("sb_id", out_id, q[0].id);
            end
            m_grant = '0;
            m_pick  = -1;
            if (cycle >= m_free && (!m_valid || in_ready)) begin
                m_pick = model_pick(in_valid, m_last);
                if (m_pick >= 0) m_grant[m_pick] = 1'b1;
            end
            check("sb_grant", out_ready_req, m_grant);
            if (m_valid && in_ready) void'(q.pop_front());
            if (m_pick >= 0) begin
                q.push_back('{model_mul(in_a[m_pick], in_b[m_pick]), m_pick, cycle + 4});
                m_last = m_pick;
                m_free = cycle + 4;
            end
        end
    end

    task automatic run_one(input int id, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] exp_c, input string name);
        int n;
        in_valid[id] = 1'b1;
        in_a[id] = a;
        in_b[id] = b;
        #1;
        for (n = 0; n < 20 && !out_ready_req[id]; n++) begin
            @(posedge in_clock); #1;
        end
        check({name, "_grant"}, out_ready_req, 1 << id);
        @(posedge in_clock); #1;
        in_valid[id] = 1'b0;
        for (n = 0; n < 20 && !out_valid; n++) begin
            @(posedge in_clock); #1;
        end
        check({name, "_latency"}, n, 3);
        check({name, "_c"}, out_c, exp_c);
        check({name, "_id"}, out_id, id);
        @(posedge in_clock); #1;
    endtask

    int g_id [$];
    int g_cyc [$];
    int n;

    initial begin
        in_reset = 1'b1;
        in_valid = '0;
        in_a     = '0;
        in_b     = '0;
        in_ready = 1'b1;
        repeat (2) @(posedge in_clock);
        #1 in_reset = 1'b0;

        check("model_69", model_mul(4'h6, 4'h9), 4'hA);
        check("model_35", model_mul(4'h3, 4'h5), 4'h1);
        check("model_ff", model_mul(4'hF, 4'hF), 4'hF);

        check("rst_valid", out_valid, 1'b0);
        check("rst_c", out_c, 4'h0);
        check("rst_id", out_id, 0);

        run_one(0, 4'h6, 4'h9, 4'hA, "t1");
        run_one(0, 4'h3, 4'h5, 4'h1, "t2");
        run_one(0, 4'hF, 4'hF, 4'hF, "t3");
        run_one(1, 4'h6, 4'h9, 4'hA, "t4");

        // Both requesters contend continuously; last grant was requester 1.
        in_a[0] = 4'h2; in_b[0] = 4'h7;
        in_a[1] = 4'hC; in_b[1] = 4'hD;
        in_valid = 2'b11;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (out_ready_req != '0) begin
                g_id.push_back(out_ready_req[1] ? 1 : 0);
                g_cyc.push_back(cycle);
            end
            @(posedge in_clock); #2;
        end
        in_valid = '0;
        check("alt_count", g_id.size(), 5);
        for (int i = 0; i < g_id.size(); i++) begin
            check("alt_id", g_id[i], i % 2);
            if (i > 0) check("alt_ii", g_cyc[i] - g_cyc[i-1], 4);
        end
        repeat (8) @(posedge in_clock);
        #1;

        // Stalled result: output holds, no grants until in_ready returns.
        in_ready = 1'b0;
        in_valid[0] = 1'b1; in_a[0] = 4'h6; in_b[0] = 4'h9;
        #1;
        for (n = 0; n < 20 && !out_ready_req[0]; n++) begin
            @(posedge in_clock); #1;
        end
        @(posedge in_clock); #1;
        in_valid[0] = 1'b0;
        for (n = 0; n < 20 && !out_valid; n++) begin
            @(posedge in_clock); #1;
        end
        check("stall_arrive", out_valid, 1'b1);
        in_valid[1] = 1'b1; in_a[1] = 4'h3; in_b[1] = 4'h5;
        for (int i = 0; i < 10; i++) begin
            @(posedge in_clock); #1;
            check("stall_ready", out_ready_req, 2'b00);
            check("stall_c", out_c, 4'hA);
            check("stall_id", out_id, 0);
            check("stall_valid", out_valid, 1'b1);
        end
        in_ready = 1'b1;
        #1;
        check("stall_bypass", out_ready_req, 2'b10);
        @(posedge in_clock); #1;
        in_valid = '0;
        repeat (8) @(posedge in_clock);
        #1;

        // Reset while the unit is in MUL_L.
        in_valid[0] = 1'b1; in_a[0] = 4'hF; in_b[0] = 4'hF;
        #1;
        for (n = 0; n < 20 && !out_ready_req[0]; n++) begin
            @(posedge in_clock); #1;
        end
        @(posedge in_clock); #1;
        in_valid[0] = 1'b0;
        @(posedge in_clock); #1;
        in_reset = 1'b1;
        @(posedge in_clock); #1;
        in_reset = 1'b0;
        check("midrst_valid", out_valid, 1'b0);
        repeat (5) @(posedge in_clock);
        #1;
        check("midrst_quiet", out_valid, 1'b0);
        in_a[1] = 4'h6; in_b[1] = 4'h9;
        in_valid = 2'b11;
        #1;
        check("midrst_first", out_ready_req, 2'b01);
        @(posedge in_clock); #1;
        in_valid = '0;
        repeat (8) @(posedge in_clock);
        #1;

`ifdef BV4_MUL_SCHED_CLEAR_EN
        check("clr_a", dut.a_q, 4'h0);
        check("clr_b", dut.b_q, 4'h0);
        check("clr_ph", dut.p_h_q, 2'b00);
        check("clr_pl", dut.p_l_q, 2'b00);
`endif

        check("drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
